// File: rtl/line_memory_ctrl_pkg.sv
// Shared definitions for the line memory controller and the cache blocks
// that talk to it: default geometry, word slicing and FSM state encodings.
`timescale 1ns/1ps
package line_memory_ctrl_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_LATENCY = 4;

    // Byte offset inside a line; these address bits never select a line.
    localparam int OFFSET_W = 4;

    // A line holds four 32-bit words, word 0 in the most significant slot.
    localparam int WORD_W    = 32;
    localparam int WORD0_LSB = 96;
    localparam int WORD1_LSB = 64;
    localparam int WORD2_LSB = 32;
    localparam int WORD3_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Countdown preload for a given latency; out-of-range values are
    // clamped into the legal 1..15 window.
    function automatic logic [3:0] lat_load(input int lat);
        if (lat < 1)
            return 4'd0;
        else if (lat > 15)
            return 4'd14;
        else
            return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/line_memory_ctrl_ram.sv
// Single-port synchronous line RAM. The array has no reset; only the
// output register is cleared so the read port starts from a known value.
`timescale 1ns/1ps
module line_memory_ctrl_ram #(
    parameter int IDX_W  = 6,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [LINE_W-1:0] mem [DEPTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    // Read register: holds its value until the next read access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/line_memory_ctrl.sv
// Main-memory controller for the write-back cache: accepts one whole-line
// read or write at a time, completes it after a fixed latency with a
// one-cycle done pulse, and keeps completed read/write counters.
`timescale 1ns/1ps
module line_memory_ctrl
    import line_memory_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReq,
    input  logic              isMemRead,
    input  logic [ADDR_W-1:0] memAddress,
    input  logic [LINE_W-1:0] memWriteData,
    output logic              memReady,
    output logic              memDone,
    output logic [LINE_W-1:0] memReadData,
    output logic [CNT_W-1:0]  rdCount,
    output logic [CNT_W-1:0]  wrCount
);

    localparam int         IDX_W    = ADDR_W - OFFSET_W;
    localparam logic [3:0] CNT_LOAD = lat_load(LATENCY);

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic               op_rd;
    logic [IDX_W-1:0]   idx;
    logic [LINE_W-1:0]  wdata_q;
    logic               accept;
    logic               finish;
    logic               unused_offset;

    // Byte offset within the line is deliberately ignored.
    assign unused_offset = ^memAddress[OFFSET_W-1:0];

    assign accept = (state == IDLE) && memReq;
    assign finish = (state == BUSY) && (cnt == 4'd0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and ready: requests are only seen in IDLE, so anything
    // asserted while BUSY is dropped rather than queued.
    always_comb begin
        state_nxt = state;
        memReady  = 1'b0;
        case (state)
            IDLE: begin
                memReady = 1'b1;
                if (memReq)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == 4'd0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency countdown, preloaded at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 4'd0;
        else if (accept)
            cnt <= CNT_LOAD;
        else if ((state == BUSY) && (cnt != 4'd0))
            cnt <= cnt - 4'd1;
    end

    // Request capture: later input changes during BUSY have no effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_rd   <= isMemRead;
            idx     <= memAddress[ADDR_W-1:OFFSET_W];
            wdata_q <= memWriteData;
        end
    end

    // Completion pulse and access statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memDone <= 1'b0;
            rdCount <= '0;
            wrCount <= '0;
        end else begin
            memDone <= finish;
            if (finish && op_rd)
                rdCount <= rdCount + CNT_W'(1);
            if (finish && !op_rd)
                wrCount <= wrCount + CNT_W'(1);
        end
    end

    line_memory_ctrl_ram #(
        .IDX_W  (IDX_W),
        .LINE_W (LINE_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (finish),
        .we    (!op_rd),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (memReadData)
    );

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed bench for line_memory_ctrl: a default-latency instance for the
// protocol/data checks and a LATENCY=1, 8-bit-counter instance for the
// randomised scoreboard run and counter wrap.
`timescale 1ns/1ps
module tb_line_memory_ctrl;
    import line_memory_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;

    logic         req, rd;
    logic [9:0]   addr;
    logic [127:0] wd;
    logic         ready, done;
    logic [127:0] rdata;
    logic [15:0]  rc, wc;

    logic         req1, rd1;
    logic [9:0]   addr1;
    logic [127:0] wd1;
    logic         ready1, done1;
    logic [127:0] rdata1;
    logic [7:0]   rc1, wc1;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] PAT_P = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] PAT_Q = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [127:0] PAT_R = 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_C3C3_3C3C;
    localparam logic [127:0] PAT_J = 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;
    localparam logic [127:0] PAT_S = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] PAT_T = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;

    line_memory_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .memReq       (req),
        .isMemRead    (rd),
        .memAddress   (addr),
        .memWriteData (wd),
        .memReady     (ready),
        .memDone      (done),
        .memReadData  (rdata),
        .rdCount      (rc),
        .wrCount      (wc)
    );

    line_memory_ctrl #(.LATENCY(1), .CNT_W(8)) u_l1 (
        .clk          (clk),
        .rst          (rst),
        .memReq       (req1),
        .isMemRead    (rd1),
        .memAddress   (addr1),
        .memWriteData (wd1),
        .memReady     (ready1),
        .memDone      (done1),
        .memReadData  (rdata1),
        .rdCount      (rc1),
        .wrCount      (wc1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the default instance; n = cycles from acceptance to
    // done, low = cycles with ready deasserted over that window.
    task automatic op_main(input logic r, input logic [9:0] a, input logic [127:0] d,
                           output int n, output int low);
        int guard = 0;
        while (!ready && guard < 50) begin
            tick();
            guard++;
        end
        req = 1'b1; rd = r; addr = a; wd = d;
        tick();
        req = 1'b0;
        n   = 0;
        low = ready ? 0 : 1;
        while (!done && n < 50) begin
            tick();
            n++;
            if (!ready) low++;
        end
    endtask

    task automatic op_l1(input logic r, input logic [9:0] a, input logic [127:0] d,
                         output int n);
        int guard = 0;
        while (!ready1 && guard < 50) begin
            tick();
            guard++;
        end
        req1 = 1'b1; rd1 = r; addr1 = a; wd1 = d;
        tick();
        req1 = 1'b0;
        n = 0;
        while (!done1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    logic [127:0] sb [64];
    logic [5:0]   wl [$];
    logic [5:0]   li;
    logic [127:0] dv;
    int           n, low;

    initial begin
        rst = 1'b1;
        req = 1'b0;  rd = 1'b0;  addr = '0;  wd = '0;
        req1 = 1'b0; rd1 = 1'b0; addr1 = '0; wd1 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ready", ready, 1'b1);
        chk("rst_done",  done,  1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_rdcnt", rc,    '0);
        chk("rst_wrcnt", wc,    '0);

        // Give line 0x10 known zero contents, then clear the counters again
        op_main(1'b0, 10'h100, '0, n, low);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("pre_wrcnt_cleared", wc, '0);

        // 1: write line 0x3
        op_main(1'b0, 10'h030, PAT_P, n, low);
        chk("t1_wr_latency", n, 4);
        chk("t1_wrcnt", wc, 16'd1);
        chk("t1_rdcnt", rc, 16'd0);
        chk("t1_rdata_untouched", rdata, '0);

        // 2/3: read same line at offset 0xC, issued in the write's done cycle
        chk("t3_ready_in_done", ready, 1'b1);
        req = 1'b1; rd = 1'b1; addr = 10'h03C; wd = PAT_J;
        tick();
        req = 1'b0;
        chk("t3_b2b_accept", ready, 1'b0);
        n = 0; low = 1;
        while (!done && n < 50) begin
            tick();
            n++;
            if (!ready) low++;
        end
        chk("t2_rd_latency", n, 4);
        chk("t2_ready_low", low, 4);
        chk("t2_rdata", rdata, PAT_P);
        chk("t2_word0", rdata[WORD0_LSB +: WORD_W], 32'h0123_4567);
        chk("t2_rdcnt", rc, 16'd1);

        // 3: write line 0x20 back-to-back, junk write requested while BUSY
        req = 1'b1; rd = 1'b0; addr = 10'h200; wd = PAT_Q;
        tick();
        addr = 10'h030; wd = PAT_J;
        tick();
        tick();
        req = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk("t3_rest_latency", n, 2);
        chk("t3_wrcnt", wc, 16'd2);
        chk("t3_rdcnt", rc, 16'd1);
        tick();
        chk("t3_done_pulse", done, 1'b0);
        chk("t3_nothing_queued", ready, 1'b1);
        op_main(1'b1, 10'h035, '0, n, low);
        chk("t3_junk_ignored", rdata, PAT_P);
        op_main(1'b1, 10'h20C, '0, n, low);
        chk("t3_rd_line20", rdata, PAT_Q);
        chk("t3_rdcnt_after", rc, 16'd3);

        // 4: reset two cycles into a write of line 0x10
        req = 1'b1; rd = 1'b0; addr = 10'h100; wd = PAT_R;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t4_async_ready", ready, 1'b1);
        chk("t4_rdcnt", rc, '0);
        chk("t4_wrcnt", wc, '0);
        chk("t4_rdata", rdata, '0);
        tick();
        chk("t4_no_done", done, 1'b0);
        rst = 1'b0;
        tick();
        op_main(1'b1, 10'h104, '0, n, low);
        chk("t4_old_contents", rdata, '0);
        chk("t4_wrcnt_after", wc, '0);

        // 5: LATENCY=1 random alternating writes and reads
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) begin
                li = 6'($urandom_range(0, 63));
                dv = {$urandom, $urandom, $urandom, $urandom};
                sb[li] = dv;
                wl.push_back(li);
                op_l1(1'b0, {li, 4'($urandom_range(0, 15))}, dv, n);
                chk("t5_wr_latency", n, 1);
            end else begin
                li = wl[$urandom_range(0, wl.size() - 1)];
                op_l1(1'b1, {li, 4'($urandom_range(0, 15))}, PAT_J, n);
                chk("t5_rd_latency", n, 1);
                chk("t5_rd_data", rdata1, sb[li]);
            end
        end
        chk("t5_rdcnt", rc1, 8'd50);
        chk("t5_wrcnt", wc1, 8'd50);

        // 6: counter wrap and read-data hold across a write
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        op_l1(1'b0, 10'h050, PAT_S, n);
        for (int i = 0; i < 255; i++)
            op_l1(1'b1, 10'h05A, '0, n);
        chk("t6_rdcnt_ff", rc1, 8'hFF);
        chk("t6_rdata", rdata1, PAT_S);
        op_l1(1'b0, 10'h050, PAT_T, n);
        chk("t6_hold_across_write", rdata1, PAT_S);
        chk("t6_wrcnt", wc1, 8'd2);
        op_l1(1'b1, 10'h05F, '0, n);
        chk("t6_rdcnt_wrap", rc1, 8'h00);
        chk("t6_new_data", rdata1, PAT_T);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
